// File: rtl/sccb_clk_pkg.sv
// rtl/sccb_clk_pkg.sv - shared types, constants and divider helper for the SCCB clock/reset generator
//
// Contents:
//   state_t    reset-sequencer state, 2-bit encoded
//   PH_*       SCL quarter-phase codes carried on SCCB_PHASE, shared with the SCCB master
//   sccb_div() PCLK cycles per SCCB bit-timing tick (4 ticks per SCL period)
package sccb_clk_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        FILTER    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam logic [1:0] PH_SCL_LO  = 2'd0;
    localparam logic [1:0] PH_SDA_CHG = 2'd1;
    localparam logic [1:0] PH_SCL_HI  = 2'd2;
    localparam logic [1:0] PH_SAMPLE  = 2'd3;

    function automatic int unsigned sccb_div(input int unsigned clk_hz,
                                             input int unsigned sccb_hz);
        return clk_hz / (4 * sccb_hz);
    endfunction

endpackage

// File: rtl/bit_sync_2ff.sv
// rtl/bit_sync_2ff.sv - generic two-flop single-bit synchronizer
//
// Ports:
//   i_clk    destination clock
//   i_rst_n  asynchronous active-low reset, both flops clear to 0
//   i_d      asynchronous input bit
//   o_q      synchronized bit, two i_clk edges behind i_d
module bit_sync_2ff (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/sccb_clk_rst_gen.sv
// rtl/sccb_clk_rst_gen.sv - lock-qualified fabric reset sequencer and SCCB bit-timing tick generator
//
// Ports:
//   i_pclk           PCLK from the CCC (RC oscillator)
//   i_presetn        asynchronous active-low reset
//   i_ccc_lock       CCC lock flag, asynchronous to PCLK
//   i_soft_rst       1-cycle pulse: restart the hold sequence (honoured only in RUN)
//   i_en             enable SCCB tick generation
//   i_lock_lost_clr  pulse: clear o_lock_lost
//   o_rst_out_n      fabric reset, active low; asserts async, deasserts on PCLK
//   o_ready          high only while in RUN
//   o_sccb_tick      1-cycle pulse at 4*SCCB_FREQ_HZ
//   o_sccb_phase     SCL quarter-phase, advances with each tick, wraps 3->0
//   o_lock_lost      sticky: lock dropped while in RUN
module sccb_clk_rst_gen
    import sccb_clk_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ      = 50_000_000,
    parameter int unsigned SCCB_FREQ_HZ     = 100_000,
    parameter int unsigned LOCK_FILTER      = 16,
    parameter int unsigned POR_DELAY_CYCLES = 1024
) (
    input  logic       i_pclk,
    input  logic       i_presetn,
    input  logic       i_ccc_lock,
    input  logic       i_soft_rst,
    input  logic       i_en,
    input  logic       i_lock_lost_clr,
    output logic       o_rst_out_n,
    output logic       o_ready,
    output logic       o_sccb_tick,
    output logic [1:0] o_sccb_phase,
    output logic       o_lock_lost
);

    localparam int unsigned DIV    = sccb_div(CLK_FREQ_HZ, SCCB_FREQ_HZ);
    localparam int unsigned DIV_W  = (DIV < 2) ? 1 : $clog2(DIV);
    localparam int unsigned FILT_W = $clog2(LOCK_FILTER + 1);
    localparam int unsigned HOLD_W = $clog2(POR_DELAY_CYCLES + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(POR_DELAY_CYCLES - 1);

    if (CLK_FREQ_HZ % (4 * SCCB_FREQ_HZ) != 0) begin : g_bad_freq
        $error("CLK_FREQ_HZ must be a multiple of 4*SCCB_FREQ_HZ");
    end
    if (DIV < 2) begin : g_bad_div
        $error("tick divider must be at least 2");
    end
    if (LOCK_FILTER < 1) begin : g_bad_filter
        $error("LOCK_FILTER must be at least 1");
    end
    if (POR_DELAY_CYCLES < 1) begin : g_bad_por
        $error("POR_DELAY_CYCLES must be at least 1");
    end

    logic              w_lock_s;
    state_t            r_state;
    logic [FILT_W-1:0] r_filt_cnt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_run;
    logic              r_lock_lost;
    logic [DIV_W-1:0]  r_div_cnt;
    logic              r_tick;
    logic [1:0]        r_phase;
    logic              w_div_run;

    bit_sync_2ff u_lock_sync (
        .i_clk   (i_pclk),
        .i_rst_n (i_presetn),
        .i_d     (i_ccc_lock),
        .o_q     (w_lock_s)
    );

    // r_run is loaded with (next state == RUN), so the fabric reset and READY
    // track the state register exactly and change on the transition edge.
    always_ff @(posedge i_pclk or negedge i_presetn) begin
        if (!i_presetn) begin
            r_state     <= WAIT_LOCK;
            r_filt_cnt  <= '0;
            r_hold_cnt  <= '0;
            r_run       <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_run <= 1'b0;
            if (i_lock_lost_clr) begin
                r_lock_lost <= 1'b0;
            end
            case (r_state)
                WAIT_LOCK: begin
                    if (w_lock_s) begin
                        r_state    <= FILTER;
                        r_filt_cnt <= FILT_W'(1);
                    end
                end
                FILTER: begin
                    if (!w_lock_s) begin
                        r_state <= WAIT_LOCK;
                    end else if (r_filt_cnt == FILT_LAST) begin
                        r_state    <= HOLD;
                        r_hold_cnt <= '0;
                    end else begin
                        r_filt_cnt <= r_filt_cnt + FILT_W'(1);
                    end
                end
                HOLD: begin
                    if (!w_lock_s) begin
                        r_state <= WAIT_LOCK;
                    end else if (r_hold_cnt == HOLD_LAST) begin
                        r_state <= RUN;
                        r_run   <= 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                    end
                end
                RUN: begin
                    // Lock loss outranks a soft restart; the set here also
                    // overrides a coincident clear above.
                    if (!w_lock_s) begin
                        r_state     <= WAIT_LOCK;
                        r_lock_lost <= 1'b1;
                    end else if (i_soft_rst) begin
                        r_state    <= HOLD;
                        r_hold_cnt <= '0;
                    end else begin
                        r_run <= 1'b1;
                    end
                end
                default: begin
                    r_state <= WAIT_LOCK;
                end
            endcase
        end
    end

    assign w_div_run = r_run & i_en;

    always_ff @(posedge i_pclk or negedge i_presetn) begin
        if (!i_presetn) begin
            r_div_cnt <= '0;
            r_tick    <= 1'b0;
            r_phase   <= PH_SCL_LO;
        end else if (!w_div_run) begin
            r_div_cnt <= '0;
            r_tick    <= 1'b0;
            r_phase   <= PH_SCL_LO;
        end else if (r_div_cnt == DIV_LAST) begin
            r_div_cnt <= '0;
            r_tick    <= 1'b1;
            r_phase   <= r_phase + 2'd1;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
            r_tick    <= 1'b0;
        end
    end

    assign o_rst_out_n  = r_run;
    assign o_ready      = r_run;
    assign o_sccb_tick  = r_tick;
    assign o_sccb_phase = r_phase;
    assign o_lock_lost  = r_lock_lost;

endmodule

// File: tb/tb_sccb_clk_rst_gen.sv
// tb/tb_sccb_clk_rst_gen.sv - self-checking bench for sccb_clk_rst_gen
module tb_sccb_clk_rst_gen;

    localparam int LF  = 16;
    localparam int PD  = 1024;
    localparam int DIV = 125;

    logic       clk = 1'b0;
    logic       presetn;
    logic       ccc_lock;
    logic       soft_rst;
    logic       en;
    logic       clr;
    logic       rst_out_n;
    logic       ready;
    logic       tick;
    logic [1:0] phase;
    logic       lock_lost;

    int errors = 0;
    int checks = 0;
    int edge_cnt = 0;

    sccb_clk_rst_gen dut (
        .i_pclk          (clk),
        .i_presetn       (presetn),
        .i_ccc_lock      (ccc_lock),
        .i_soft_rst      (soft_rst),
        .i_en            (en),
        .i_lock_lost_clr (clr),
        .o_rst_out_n     (rst_out_n),
        .o_ready         (ready),
        .o_sccb_tick     (tick),
        .o_sccb_phase    (phase),
        .o_lock_lost     (lock_lost)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge presetn) begin
        if (!presetn) edge_cnt = 0;
        else          edge_cnt = edge_cnt + 1;
    end

    // Behavioural model: READY is high once lock_s has been seen high for
    // LF+PD+1 consecutive edges and at least PD edges have passed since a
    // soft restart taken in RUN. Ticks come every DIV running edges.
    int m_d1, m_d2, m_ls, m_streak, m_since_soft;
    int m_ready, m_lost, m_run_cnt, m_tick, m_phase, m_prev_ready;

    always @(posedge clk or negedge presetn) begin
        if (!presetn) begin
            m_d1 = 0; m_d2 = 0; m_streak = 0; m_since_soft = PD;
            m_ready = 0; m_lost = 0; m_run_cnt = 0; m_tick = 0; m_phase = 0;
        end else begin
            m_ls = m_d2;
            m_d2 = m_d1;
            m_d1 = int'(ccc_lock);
            m_prev_ready = m_ready;
            if (m_prev_ready != 0 && en) m_run_cnt = m_run_cnt + 1;
            else                         m_run_cnt = 0;
            m_tick  = (m_run_cnt > 0 && m_run_cnt % DIV == 0) ? 1 : 0;
            m_phase = (m_run_cnt / DIV) % 4;
            m_streak = (m_ls != 0) ? m_streak + 1 : 0;
            if (m_prev_ready != 0 && m_ls != 0 && soft_rst) m_since_soft = 0;
            else if (m_since_soft < PD)                      m_since_soft = m_since_soft + 1;
            if (m_prev_ready != 0 && m_ls == 0) m_lost = 1;
            else if (clr)                       m_lost = 0;
            m_ready = (m_streak >= LF + PD + 1 && m_since_soft >= PD) ? 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (presetn) begin
            check("cmp_rst_out_n", int'(rst_out_n), m_ready);
            check("cmp_ready", int'(ready), m_ready);
            check("cmp_tick", int'(tick), m_tick);
            check("cmp_phase", int'(phase), m_phase);
            check("cmp_lock_lost", int'(lock_lost), m_lost);
        end
    end

    task automatic wait_edge(input int n);
        int guard = 0;
        while (edge_cnt < n && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check("wait_edge_reached", edge_cnt, n);
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (!ready && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("wait_ready_timeout", int'(ready), 1);
    endtask

    int e0, d, g, s0, h;

    initial begin
        presetn = 1'b0; ccc_lock = 1'b1; soft_rst = 1'b0; en = 1'b0; clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rst_out_n", int'(rst_out_n), 0);
        check("rst_ready", int'(ready), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_phase", int'(phase), 0);
        check("rst_lock_lost", int'(lock_lost), 0);

        // 1: lock already present at reset release, rise at edge 1043
        presetn = 1'b1;
        wait_edge(1042);
        check("t1_rst_before_1043", int'(rst_out_n), 0);
        check("t1_model_before_1043", m_ready, 0);
        @(negedge clk);
        check("t1_rst_at_1043", int'(rst_out_n), 1);
        check("t1_ready_at_1043", int'(ready), 1);
        check("t1_model_at_1043", m_ready, 1);

        // 3: tick every 125 cycles, phase 1,2,3,0,1
        e0 = edge_cnt;
        en = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            wait_edge(e0 + DIV * k - 1);
            check("t3_no_tick_before", int'(tick), 0);
            @(negedge clk);
            check("t3_tick", int'(tick), 1);
            check("t3_phase", int'(phase), k % 4);
            check("t3_model_phase", m_phase, k % 4);
        end
        en = 1'b0;
        @(negedge clk);
        check("t3_phase_cleared", int'(phase), 0);
        check("t3_tick_cleared", int'(tick), 0);

        // 4: lock loss in RUN, coincident clear
        d = edge_cnt;
        ccc_lock = 1'b0;
        wait_edge(d + 2);
        check("t4_rst_still_high", int'(rst_out_n), 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("t4_rst_low", int'(rst_out_n), 0);
        check("t4_ready_low", int'(ready), 0);
        check("t4_lost_set_wins", int'(lock_lost), 1);
        @(negedge clk);
        check("t4_lost_sticky", int'(lock_lost), 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("t4_lost_cleared", int'(lock_lost), 0);
        soft_rst = 1'b1;
        @(negedge clk);
        soft_rst = 1'b0;
        repeat (3) @(negedge clk);

        // 2: glitchy lock, 10 high, 1 low, then steady
        ccc_lock = 1'b1;
        repeat (10) @(negedge clk);
        ccc_lock = 1'b0;
        @(negedge clk);
        ccc_lock = 1'b1;
        g = edge_cnt + 1;
        wait_edge(g + 1041);
        check("t2_rst_before", int'(rst_out_n), 0);
        @(negedge clk);
        check("t2_rst_rise", int'(rst_out_n), 1);

        // 5: soft restart in RUN, then soft restart with lock loss
        s0 = edge_cnt;
        soft_rst = 1'b1;
        @(negedge clk);
        soft_rst = 1'b0;
        check("t5_rst_low_next", int'(rst_out_n), 0);
        check("t5_lost_clear", int'(lock_lost), 0);
        wait_edge(s0 + PD);
        check("t5_rst_still_low", int'(rst_out_n), 0);
        @(negedge clk);
        check("t5_rst_rise", int'(rst_out_n), 1);
        check("t5_lost_still_clear", int'(lock_lost), 0);
        d = edge_cnt;
        ccc_lock = 1'b0;
        wait_edge(d + 2);
        soft_rst = 1'b1;
        @(negedge clk);
        soft_rst = 1'b0;
        check("t5_both_lost", int'(lock_lost), 1);
        check("t5_both_rst", int'(rst_out_n), 0);
        @(negedge clk);
        check("t5_both_stays_low", int'(rst_out_n), 0);

        // 6: async reset mid-HOLD and mid-RUN
        ccc_lock = 1'b1;
        h = edge_cnt + 1;
        wait_edge(h + 500);
        #5;
        presetn = 1'b0;
        #1;
        check("t6_hold_rst_async", int'(rst_out_n), 0);
        check("t6_hold_ready_async", int'(ready), 0);
        @(negedge clk);
        presetn = 1'b1;
        wait_edge(1042);
        check("t6_restart_before", int'(rst_out_n), 0);
        @(negedge clk);
        check("t6_restart_rise", int'(rst_out_n), 1);
        e0 = edge_cnt;
        en = 1'b1;
        wait_edge(e0 + 2 * DIV + 10);
        check("t6_phase_running", int'(phase), 2);
        #5;
        presetn = 1'b0;
        #1;
        check("t6_run_rst_async", int'(rst_out_n), 0);
        check("t6_run_ready_async", int'(ready), 0);
        check("t6_run_tick_async", int'(tick), 0);
        check("t6_run_phase_async", int'(phase), 0);
        check("t6_run_lost_async", int'(lock_lost), 0);
        @(negedge clk);
        presetn = 1'b1;
        wait_edge(1042);
        check("t6_second_before", int'(rst_out_n), 0);
        @(negedge clk);
        check("t6_second_rise", int'(rst_out_n), 1);
        wait_ready();
        repeat (DIV + 5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
